// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and constants for the branch predictor: the
//               2-bit PHT counter encoding, the BTB entry layout and the
//               counter reset/allocation values.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // 2-bit saturating branch-direction counter; the MSB is the prediction.
    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } ctr_t;

    // BTB field widths are sized for the widest supported configuration
    // (XLEN <= 64, TAG_W <= 32). Narrower configurations store zero-extended
    // values, so the unused upper flops are constant and trim away.
    localparam int C_BTB_TAG_W    = 32;
    localparam int C_BTB_TARGET_W = 64;

    typedef struct packed {
        logic                      valid;
        logic                      jmp;
        logic [C_BTB_TAG_W-1:0]    tag;
        logic [C_BTB_TARGET_W-1:0] target;
    } btb_entry_t;

    localparam ctr_t       C_CTR_RESET       = WEAK_NT;
    localparam ctr_t       C_CTR_ALLOC_BR    = WEAK_T;
    localparam ctr_t       C_CTR_ALLOC_JMP   = STRONG_T;
    localparam btb_entry_t C_BTB_ENTRY_RESET = '0;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : bp_sat_counter
// Description : Combinational next-state function of a 2-bit saturating
//               branch counter. An allocation loads weakly-taken (or
//               strongly-taken for jumps); otherwise the counter moves one
//               step toward the resolved outcome and saturates at the ends.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t cur,
    input  logic taken,
    input  logic alloc,
    input  logic is_jmp,
    output ctr_t next_ctr
);

    // Next counter value for one resolved update
    always_comb begin
        next_ctr = cur;
        if (alloc) begin
            next_ctr = is_jmp ? C_CTR_ALLOC_JMP : C_CTR_ALLOC_BR;
        end else if (taken) begin
            if (cur != STRONG_T) begin
                next_ctr = ctr_t'(cur + 2'd1);
            end
        end else begin
            if (cur != STRONG_NT) begin
                next_ctr = ctr_t'(cur - 2'd1);
            end
        end
    end

endmodule : bp_sat_counter
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Dynamic fetch-stage branch predictor. A direct-mapped BTB
//               (valid, tag, target, jump flag) supplies the target, and a
//               PHT of 2-bit saturating counters supplies the direction.
//               Lookup is combinational; execute-stage updates are written
//               one per clock with no write-to-read bypass.
//               Optional macro BRANCH_PREDICTOR_GSHARE_EN adds a global
//               history register XOR-ed into the PHT index.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int TAG_W = 8,
    parameter int GHR_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            pred_taken_o,
    output logic            pred_hit_o,
    output logic [XLEN-1:0] pred_next_pc_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            upd_is_jmp_i
);

    localparam int IDX_W = $clog2(DEPTH);

    btb_entry_t       r_btb [DEPTH];
    ctr_t             r_pht [DEPTH];

    logic [IDX_W-1:0] w_f_idx;
    logic [IDX_W-1:0] w_f_pidx;
    logic [TAG_W-1:0] w_f_tag;
    btb_entry_t       w_f_ent;
    ctr_t             w_f_ctr;
    logic             w_f_hit;

    logic [IDX_W-1:0] w_u_idx;
    logic [IDX_W-1:0] w_u_pidx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic             w_alloc;
    ctr_t             w_u_ctr_cur;
    ctr_t             w_u_ctr_nxt;
    btb_entry_t       w_u_new_ent;
    logic             w_unused_upd_pc;

    // Word-aligned index and tag; pc[1:0] and bits above the tag are ignored
    assign w_f_idx = fetch_pc_i[IDX_W+1:2];
    assign w_f_tag = fetch_pc_i[IDX_W+2+TAG_W-1:IDX_W+2];
    assign w_u_idx = upd_pc_i[IDX_W+1:2];
    assign w_u_tag = upd_pc_i[IDX_W+2+TAG_W-1:IDX_W+2];

    // Only the index/tag slices of the update PC matter
    assign w_unused_upd_pc = ^upd_pc_i;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_W-1:0] r_ghr;

    // PHT index folds in the committed global history (BTB stays PC-indexed)
    assign w_f_pidx = w_f_idx ^ IDX_W'(r_ghr);
    assign w_u_pidx = w_u_idx ^ IDX_W'(r_ghr);

    // Non-speculative history: shift in each resolved conditional outcome
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ghr <= '0;
        end else if (upd_valid_i && !upd_is_jmp_i) begin
            r_ghr <= GHR_W'({r_ghr, upd_taken_i});
        end
    end
`else
    localparam int c_unused_ghr_w = GHR_W;

    assign w_f_pidx = w_f_idx;
    assign w_u_pidx = w_u_idx;
`endif

    // ---------------- lookup (combinational) ----------------
    assign w_f_ent = r_btb[w_f_idx];
    assign w_f_ctr = r_pht[w_f_pidx];
    assign w_f_hit = w_f_ent.valid && (w_f_ent.tag == C_BTB_TAG_W'(w_f_tag));

    assign pred_hit_o     = w_f_hit;
    assign pred_taken_o   = w_f_hit && (w_f_ent.jmp || (w_f_ctr >= WEAK_T));
    assign pred_next_pc_o = pred_taken_o ? XLEN'(w_f_ent.target)
                                         : fetch_pc_i + XLEN'(4);

    // ---------------- update path ----------------
    assign w_u_hit = r_btb[w_u_idx].valid &&
                     (r_btb[w_u_idx].tag == C_BTB_TAG_W'(w_u_tag));
    // An alias (valid entry, other tag) counts as a miss and is replaced
    assign w_alloc     = !w_u_hit && upd_taken_i;
    assign w_u_ctr_cur = r_pht[w_u_pidx];

    assign w_u_new_ent = '{valid:  1'b1,
                           jmp:    upd_is_jmp_i,
                           tag:    C_BTB_TAG_W'(w_u_tag),
                           target: C_BTB_TARGET_W'(upd_target_i)};

    bp_sat_counter u_sat_counter (
        .cur      (w_u_ctr_cur),
        .taken    (upd_taken_i),
        .alloc    (w_alloc),
        .is_jmp   (upd_is_jmp_i),
        .next_ctr (w_u_ctr_nxt)
    );

    // Table write: counter always moves; BTB written only on taken outcomes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_btb[i] <= C_BTB_ENTRY_RESET;
                r_pht[i] <= C_CTR_RESET;
            end
        end else if (upd_valid_i) begin
            r_pht[w_u_pidx] <= w_u_ctr_nxt;
            if (upd_taken_i) begin
                r_btb[w_u_idx] <= w_u_new_ent;
            end
        end
    end

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor. Directed scenarios
//               plus randomized traffic, compared against a table-level
//               behavioural model. Honours BRANCH_PREDICTOR_GSHARE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int TAG_W = 8;
    localparam int GHR_W = 6;
    localparam int IW    = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] fetch_pc = '0;
    logic            pred_taken;
    logic            pred_hit;
    logic [XLEN-1:0] pred_next_pc;
    logic            upd_valid = 1'b0;
    logic [XLEN-1:0] upd_pc = '0;
    logic            upd_taken = 1'b0;
    logic [XLEN-1:0] upd_target = '0;
    logic            upd_is_jmp = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // last observed outputs of step()
    logic            last_hit;
    logic            last_taken;
    logic [XLEN-1:0] last_next;

    // behavioural model state
    bit              m_valid [DEPTH];
    bit              m_jmp   [DEPTH];
    int unsigned     m_tag   [DEPTH];
    logic [XLEN-1:0] m_tgt   [DEPTH];
    int              m_ctr   [DEPTH];
    int unsigned     m_ghr;

    branch_predictor #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .GHR_W (GHR_W)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fetch_pc_i     (fetch_pc),
        .pred_taken_o   (pred_taken),
        .pred_hit_o     (pred_hit),
        .pred_next_pc_o (pred_next_pc),
        .upd_valid_i    (upd_valid),
        .upd_pc_i       (upd_pc),
        .upd_taken_i    (upd_taken),
        .upd_target_i   (upd_target),
        .upd_is_jmp_i   (upd_is_jmp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned f_idx(input logic [XLEN-1:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic int unsigned f_tag(input logic [XLEN-1:0] pc);
        return int'((pc / (4 * DEPTH)) % (1 << TAG_W));
    endfunction

    function automatic int unsigned f_pidx(input int unsigned idx);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        return idx ^ m_ghr;
`else
        return idx;
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_jmp[i]   = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_ghr = 0;
    endtask

    task automatic m_update(input logic [XLEN-1:0] pc, input bit taken,
                            input logic [XLEN-1:0] tgt, input bit jmp);
        int unsigned idx;
        int unsigned pidx;
        bit          hit;
        idx  = f_idx(pc);
        pidx = f_pidx(idx);
        hit  = m_valid[idx] && (m_tag[idx] == f_tag(pc));
        if (taken && !hit)
            m_ctr[pidx] = jmp ? 3 : 2;
        else if (taken)
            m_ctr[pidx] = (m_ctr[pidx] < 3) ? m_ctr[pidx] + 1 : 3;
        else
            m_ctr[pidx] = (m_ctr[pidx] > 0) ? m_ctr[pidx] - 1 : 0;
        if (taken) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = f_tag(pc);
            m_tgt[idx]   = tgt;
            m_jmp[idx]   = jmp;
        end
        if (!jmp)
            m_ghr = ((m_ghr << 1) | (taken ? 1 : 0)) % (1 << GHR_W);
    endtask

    // One cycle: drive lookup + update, check lookup against pre-update model
    task automatic step(input logic [XLEN-1:0] fpc, input bit uv,
                        input logic [XLEN-1:0] upc, input bit ut,
                        input logic [XLEN-1:0] utgt, input bit uj);
        int unsigned     idx;
        bit              e_hit;
        bit              e_tk;
        logic [XLEN-1:0] e_nxt;
        @(negedge clk);
        fetch_pc   = fpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utgt;
        upd_is_jmp = uj;
        #1;
        idx   = f_idx(fpc);
        e_hit = m_valid[idx] && (m_tag[idx] == f_tag(fpc));
        e_tk  = e_hit && (m_jmp[idx] || (m_ctr[f_pidx(idx)] >= 2));
        e_nxt = e_tk ? m_tgt[idx] : fpc + 32'd4;
        check_eq("hit", 64'(pred_hit), 64'(e_hit));
        check_eq("taken", 64'(pred_taken), 64'(e_tk));
        check_eq("next_pc", 64'(pred_next_pc), 64'(e_nxt));
        last_hit   = pred_hit;
        last_taken = pred_taken;
        last_next  = pred_next_pc;
        @(posedge clk);
        #1;
        if (uv) m_update(upc, ut, utgt, uj);
    endtask

    task automatic look(input logic [XLEN-1:0] fpc);
        step(fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(input logic [XLEN-1:0] pc, input bit t,
                       input logic [XLEN-1:0] tgt, input bit j);
        step(32'h0000_0ff0, 1'b1, pc, t, tgt, j);
    endtask

    initial begin
        logic [XLEN-1:0] alias_pc;
        logic [XLEN-1:0] rpc;
        logic [XLEN-1:0] rfpc;
        bit              rt;
        bit              rj;
        bit              rv;

        m_reset();
        alias_pc = 32'h0000_0100 + 32'(4 * DEPTH);

        // reset state, observed while reset is held
        fetch_pc = 32'h0000_0100;
        #12;
        check_eq("rst_hit", 64'(pred_hit), 64'd0);
        check_eq("rst_taken", 64'(pred_taken), 64'd0);
        check_eq("rst_next_pc", 64'(pred_next_pc), 64'h104);
        @(negedge clk);
        rst_n = 1'b1;

        look(32'h0000_0100);
        check_eq("tp_cold_next", 64'(last_next), 64'h104);

        // allocation of a conditional branch; same-cycle lookup sees old state
        step(32'h0000_0100, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0040, 1'b0);
        check_eq("tp_alloc_nobypass", 64'(last_hit), 64'd0);
        look(32'h0000_0100);
        check_eq("tp_alloc_taken", 64'(last_taken), 64'd1);
        check_eq("tp_alloc_next", 64'(last_next), 64'h40);

        // two not-taken -> STRONG_NT, then a third saturates
        upd(32'h0000_0100, 1'b0, 32'h0, 1'b0);
        upd(32'h0000_0100, 1'b0, 32'h0, 1'b0);
        look(32'h0000_0100);
        check_eq("tp_nt_hit", 64'(last_hit), 64'd1);
        check_eq("tp_nt_taken", 64'(last_taken), 64'd0);
        check_eq("tp_nt_next", 64'(last_next), 64'h104);
        upd(32'h0000_0100, 1'b0, 32'h0, 1'b0);
        upd(32'h0000_0100, 1'b1, 32'h0000_0040, 1'b0);
        look(32'h0000_0100);
        check_eq("tp_sat_low", 64'(last_taken), 64'd0);

        // alias replaces the entry
        upd(alias_pc, 1'b1, 32'h0000_0300, 1'b0);
        look(32'h0000_0100);
        check_eq("tp_alias_old_miss", 64'(last_hit), 64'd0);
        look(alias_pc);
        check_eq("tp_alias_new_hit", 64'(last_hit), 64'd1);
        check_eq("tp_alias_new_next", 64'(last_next), 64'h300);

        // unconditional jump predicted taken regardless of counter
        upd(32'h0000_0280, 1'b1, 32'h0000_0800, 1'b1);
        upd(32'h0000_0280, 1'b0, 32'h0, 1'b1);
        upd(32'h0000_0280, 1'b0, 32'h0, 1'b1);
        look(32'h0000_0280);
        check_eq("tp_jal_taken", 64'(last_taken), 64'd1);
        check_eq("tp_jal_next", 64'(last_next), 64'h800);

        // same-cycle update and lookup of 0x180
        step(32'h0000_0180, 1'b1, 32'h0000_0180, 1'b1, 32'h0000_1000, 1'b0);
        check_eq("tp_same_cycle_miss", 64'(last_hit), 64'd0);
        look(32'h0000_0180);
        check_eq("tp_next_cycle_hit", 64'(last_next), 64'h1000);

        // next-pc wraps modulo 2^XLEN
        look(32'hffff_fffc);
        check_eq("tp_wrap_next", 64'(last_next), 64'h0);

        // update inputs ignored while upd_valid is low
        step(32'h0000_0180, 1'b0, 32'h0000_0180, 1'b1, 32'h0000_2000, 1'b1);
        look(32'h0000_0180);
        check_eq("tp_novalid_next", 64'(last_next), 64'h1000);

        // asynchronous reset mid-cycle with an update in flight
        @(negedge clk);
        fetch_pc   = 32'h0000_0180;
        upd_valid  = 1'b1;
        upd_pc     = 32'h0000_0180;
        upd_taken  = 1'b1;
        upd_target = 32'h000d_ead0;
        upd_is_jmp = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_hit", 64'(pred_hit), 64'd0);
        check_eq("rst_async_next", 64'(pred_next_pc), 64'h184);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n     = 1'b1;
        look(32'h0000_0180);
        check_eq("rst_inflight_dropped", 64'(last_hit), 64'd0);

        // history effect: three taken updates at the same PC
        upd(32'h0000_0400, 1'b1, 32'h0000_0500, 1'b0);
        upd(32'h0000_0400, 1'b1, 32'h0000_0500, 1'b0);
        upd(32'h0000_0400, 1'b1, 32'h0000_0500, 1'b0);
        look(32'h0000_0400);
        check_eq("tp_hist_hit", 64'(last_hit), 64'd1);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        check_eq("tp_gshare_taken", 64'(last_taken), 64'd0);
`else
        check_eq("tp_pc_idx_taken", 64'(last_taken), 64'd1);
`endif

        // randomized traffic over a small PC pool so entries collide and hit
        for (int n = 0; n < 400; n++) begin
            rpc  = (32'($urandom_range(0, 3)) << (IW + 2)) |
                   (32'($urandom_range(0, 7)) << 2) |
                   32'($urandom_range(0, 3)) |
                   (32'($urandom_range(0, 1)) << 20);
            rfpc = ($urandom_range(0, 3) == 0) ? rpc :
                   ((32'($urandom_range(0, 3)) << (IW + 2)) |
                    (32'($urandom_range(0, 7)) << 2) |
                    (32'($urandom_range(0, 1)) << 21));
            rv   = ($urandom_range(0, 3) != 0);
            rj   = ($urandom_range(0, 4) == 0);
            rt   = rj ? 1'b1 : 1'($urandom_range(0, 1));
            step(rfpc, rv, rpc, rt, 32'($urandom), rj);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_branch_predictor
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined core's fetch stage, replacing the static pc+4 fall-through of the single-cycle PC mux.
- Combines a direct-mapped branch target buffer (BTB: valid, tag, target, jump flag) with a pattern history table (PHT) of 2-bit saturating counters.
- Fetch reads it combinationally each cycle; the execute stage writes resolved branch outcomes back one update per clock.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 64, BTB and PHT entries; power of two, >= 4.
- TAG_W, 8, stored tag bits; TAG_W <= XLEN-2-log2(DEPTH).
- GHR_W, 6, global history length; used only with GSHARE_EN; GHR_W <= log2(DEPTH).

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  asynchronous active-low reset.
- fetch_pc_i  input  XLEN  PC being fetched this cycle.
- pred_taken_o  output  1  predict redirect.
- pred_hit_o  output  1  BTB hit for fetch_pc_i.
- pred_next_pc_o  output  XLEN  predicted next PC.
- upd_valid_i  input  1  resolved control-transfer instruction in EX.
- upd_pc_i  input  XLEN  PC of resolved instruction.
- upd_taken_i  input  1  actual outcome.
- upd_target_i  input  XLEN  actual target (ALU result).
- upd_is_jmp_i  input  1  JAL/JALR (unconditional).

Behaviour:
- Reset is asynchronous, active-low, single clock domain.
- Reset state: all BTB valid bits = 0; all PHT counters = 2'b01 (weakly not-taken); GHR = 0. Outputs are combinational from the tables, so during and after reset pred_hit_o = 0, pred_taken_o = 0, pred_next_pc_o = fetch_pc_i + 4.
- Index and tag:
  - IDX = pc[log2(DEPTH)+1 : 2].
  - TAG = pc[log2(DEPTH)+2+TAG_W-1 : log2(DEPTH)+2].
  - pc[1:0] is ignored.
- Lookup (combinational, 0-cycle latency):
  - hit = valid[IDX] && tag[IDX] == TAG.
  - pred_taken_o = hit && (jmp[IDX] || pht[PIDX][1]).
  - pred_next_pc_o = pred_taken_o ? target[IDX] : fetch_pc_i + 4, computed modulo 2^XLEN.
  - PIDX = IDX without GSHARE_EN.
- Update (registered, takes effect on the rising edge when upd_valid_i = 1):
  - Miss and taken: allocate the entry (valid = 1, tag, target, jmp = upd_is_jmp_i). Set the PHT counter to 2'b10 (weakly taken), or 2'b11 if a jump.
  - Miss and not-taken: BTB unchanged. PHT counter still decrements, saturating at 0.
  - Hit and taken: target overwritten; jmp overwritten; counter +1, saturating at 2'b11.
  - Hit and not-taken: counter -1, saturating at 2'b00; target kept.
  - Hit on a different tag (alias): treated as a miss, so an allocation replaces the entry.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents. There is no write-to-read bypass; the new contents are visible the next cycle.
- upd_valid_i = 0: no state change, regardless of other update inputs.
- Reset asserted mid-operation: every table clears immediately, and any in-flight update is discarded.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - A GHR_W-bit global history register is added.
  - PIDX = IDX XOR zero-extended GHR, for both lookup and update, using the current GHR value.
  - On each update with upd_valid_i = 1 and upd_is_jmp_i = 0, the GHR shifts left with upd_taken_i inserted at bit 0. This shift is non-speculative.
- Undefined: no GHR exists; PIDX = IDX; the PHT is purely PC-indexed.
- The BTB is always PC-indexed in both builds.

Decomposition:
- Shared package bp_pkg holds:
  - typedef enum of the 2-bit counter: STRONG_NT = 0, WEAK_NT = 1, WEAK_T = 2, STRONG_T = 3.
  - The BTB entry struct (valid, jmp, tag, target).
  - Constants for the counter reset value and allocation values.
- One natural sub-module, bp_sat_counter: a combinational 2-bit saturating next-state function taking inputs (cur, taken, alloc, is_jmp). It is instantiated once, in the update path.

Test Plan:
- Reset, then fetch_pc_i = 0x0000_0100 -> hit = 0, taken = 0, next_pc = 0x0000_0104.
- Update pc = 0x100, taken, target = 0x0000_0040, not jmp; next cycle fetch 0x100 -> hit = 1, taken = 1 (counter WEAK_T), next_pc = 0x40.
- Then two not-taken updates at 0x100 -> counter goes WEAK_T -> WEAK_NT -> STRONG_NT; fetch 0x100 gives hit = 1, taken = 0, next_pc = 0x104. A third not-taken update leaves it at STRONG_NT (saturation).
- JAL at 0x200, target 0x800 -> allocation sets jmp = 1; fetch 0x200 predicts taken to 0x800 regardless of counter.
- Alias: allocate 0x100, then taken update at 0x100 + 4*DEPTH (same index, different tag, target 0x300) -> fetch 0x100 misses; the new PC hits with target 0x300.
- Update and lookup of 0x180 in the same cycle -> lookup shows the old (miss) state; the following cycle hits.
- With GSHARE_EN: three taken conditional updates -> GHR = 0b000111. The same PC then maps to PHT index IDX ^ 7; check via the predicted outcome.
